// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, prefix-FSM state type and helpers for the
// PS/2 scan-code receiver (ps2_frame_rx, ps2_scan_code_rx).
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    PFX_IDLE    = 2'd0,
    PFX_BRK     = 2'd1,
    PFX_EXT     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } pfx_state_e;

  // Bytes with no key meaning when no prefix is pending: keyboard status
  // replies, error/overrun codes, and the pause sequence lead-in.
  function automatic logic is_idle_discard(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF) ||
           (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame deserialiser.
// Synchronises PS2_CLK/PS2_DAT, detects falling clock edges, shifts in an
// 11-bit frame (start, D0..D7, odd parity, stop) and checks it. A frame left
// incomplete for TIMEOUT_CYCLES system clocks is abandoned.
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous reset, active-low
//   ps2_clk_i   raw keyboard clock (asynchronous)
//   ps2_dat_i   raw keyboard data (asynchronous)
//   byte_o      received data byte, valid while byte_ok_o is high
//   byte_ok_o   one-cycle pulse: good frame in the stop-bit event cycle
//   byte_err_o  one-cycle pulse: parity/stop failure or timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_ok_o,
  output logic       byte_err_o
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_IDLE      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_PARITY    = CNT_W'(9);
  localparam logic [CNT_W-1:0] CNT_STOP      = CNT_W'(10);
  localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

  logic clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchronisers preset to the idle-high line level so reset itself never
  // looks like a clock edge while the keyboard is idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_s;
    end
  end

  // bit_cnt_q: 0 = idle waiting for start, 1..8 = expecting D0..D7,
  // 9 = expecting parity, 10 = expecting stop.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    to_cnt_d   = to_cnt_q;
    byte_ok_o  = 1'b0;
    byte_err_o = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == CNT_IDLE) begin
        // A start bit read as 1 is treated as noise.
        if (!dat_s) bit_cnt_d = CNT_W'(1);
      end else if (bit_cnt_q <= CNT_LAST_DATA) begin
        shift_d   = {dat_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else if (bit_cnt_q == CNT_PARITY) begin
        parity_d  = dat_s;
        bit_cnt_d = CNT_STOP;
      end else begin
        bit_cnt_d = CNT_IDLE;
        // Odd parity: data plus parity bit must hold an odd number of ones.
        if (dat_s && (^{shift_q, parity_q})) byte_ok_o  = 1'b1;
        else                                 byte_err_o = 1'b1;
      end
    end else if (bit_cnt_q != CNT_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        byte_err_o = 1'b1;
        bit_cnt_d  = CNT_IDLE;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bit_cnt_q <= CNT_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_scan_code_rx.sv
// ps2_scan_code_rx: PS/2 keyboard receiver front end for the digit decoder.
// Deserialises frames (ps2_frame_rx), strips break (F0) and extended (E0)
// prefixes, and presents each key-press make code as a held byte.
// Ports:
//   CLOCK_50       system clock, rising edge
//   resetn         synchronous reset, active-low
//   PS2_CLK        keyboard clock, asynchronous, idle high (input only)
//   PS2_DAT        keyboard data, asynchronous, idle high (input only)
//   make_code      last accepted make code, held until the next make
//   make_valid     one-cycle pulse when make_code is updated
//   make_extended  1 when the current make_code was E0-prefixed
//   key_released   one-cycle pulse when a break sequence completes
//   frame_error    one-cycle pulse on parity, stop-bit or timeout failure
module ps2_scan_code_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] make_code,
  output logic       make_valid,
  output logic       make_extended,
  output logic       key_released,
  output logic       frame_error
);

  logic [7:0] rx_byte;
  logic       rx_ok, rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk_i     (CLOCK_50),
    .rst_ni    (resetn),
    .ps2_clk_i (PS2_CLK),
    .ps2_dat_i (PS2_DAT),
    .byte_o    (rx_byte),
    .byte_ok_o (rx_ok),
    .byte_err_o(rx_err)
  );

  pfx_state_e state_q, state_d;
  logic [7:0] make_code_q, make_code_d;
  logic       make_ext_q, make_ext_d;
  logic       make_valid_q, make_valid_d;
  logic       key_rel_q, key_rel_d;
  logic       frame_err_q, frame_err_d;

  // Prefix FSM advances only on good bytes; a bad frame leaves it untouched.
  always_comb begin
    state_d      = state_q;
    make_code_d  = make_code_q;
    make_ext_d   = make_ext_q;
    make_valid_d = 1'b0;
    key_rel_d    = 1'b0;
    frame_err_d  = rx_err;
    if (rx_ok) begin
      case (state_q)
        PFX_IDLE: begin
          if (rx_byte == PS2_BREAK) begin
            state_d = PFX_BRK;
          end else if (rx_byte == PS2_EXT) begin
            state_d = PFX_EXT;
          end else if (!is_idle_discard(rx_byte)) begin
            make_code_d  = rx_byte;
            make_ext_d   = 1'b0;
            make_valid_d = 1'b1;
          end
        end
        PFX_EXT: begin
          if (rx_byte == PS2_BREAK) begin
            state_d = PFX_EXT_BRK;
          end else if (rx_byte != PS2_EXT) begin
            make_code_d  = rx_byte;
            make_ext_d   = 1'b1;
            make_valid_d = 1'b1;
            state_d      = PFX_IDLE;
          end
        end
        PFX_BRK, PFX_EXT_BRK: begin
          key_rel_d = 1'b1;
          state_d   = PFX_IDLE;
        end
        default: state_d = PFX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= PFX_IDLE;
      make_code_q  <= 8'h00;
      make_ext_q   <= 1'b0;
      make_valid_q <= 1'b0;
      key_rel_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      make_code_q  <= make_code_d;
      make_ext_q   <= make_ext_d;
      make_valid_q <= make_valid_d;
      key_rel_q    <= key_rel_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign make_code     = make_code_q;
  assign make_extended = make_ext_q;
  assign make_valid    = make_valid_q;
  assign key_released  = key_rel_q;
  assign frame_error   = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_code_rx.sv
// Bench for ps2_scan_code_rx: directed scenarios followed by random byte
// streams, checked against a byte-level model of the prefix rules.
module tb_ps2_scan_code_rx;

  localparam int SYNC = 2;
  localparam int TO   = 400;   // shortened timeout keeps the run small
  localparam int HALF = 10;    // PS/2 half period in system clocks

  logic       clk = 1'b0;
  logic       resetn;
  logic       PS2_CLK, PS2_DAT;
  logic [7:0] make_code;
  logic       make_valid, make_extended, key_released, frame_error;

  ps2_scan_code_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .PS2_CLK      (PS2_CLK),
    .PS2_DAT      (PS2_DAT),
    .make_code    (make_code),
    .make_valid   (make_valid),
    .make_extended(make_extended),
    .key_released (key_released),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int mv_cnt = 0, kr_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int mv_cyc = 0, fe_cyc = 0;
  always @(negedge clk) begin
    if (make_valid) begin
      mv_cnt <= mv_cnt + 1;
      mv_cyc <= cyc;
    end
    if (key_released) kr_cnt <= kr_cnt + 1;
    if (frame_error) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (make_valid && key_released) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish within 2ms");
    $fatal(1, "watchdog");
  end

  int tests = 0, fails = 0;
  int last_fall = 0;

  // Reference model: pending prefix bytes kept as a queue.
  logic [7:0] pq[$];
  logic [7:0] m_code = 8'h00;
  logic       m_ext  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, output int mv, output int kr);
    logic has_brk;
    mv = 0;
    kr = 0;
    has_brk = 1'b0;
    foreach (pq[i]) if (pq[i] == 8'hF0) has_brk = 1'b1;
    if (has_brk) begin
      kr = 1;
      pq.delete();
    end else if (pq.size() > 0) begin
      if (b == 8'hF0) pq.push_back(b);
      else if (b != 8'hE0) begin
        m_code = b; m_ext = 1'b1; mv = 1; pq.delete();
      end
    end else if (b == 8'hF0 || b == 8'hE0) begin
      pq.push_back(b);
    end else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1})) begin
      m_code = b; m_ext = 1'b0; mv = 1;
    end
  endfunction

  task automatic ps2_bit(input logic b);
    repeat (HALF / 2) @(negedge clk);
    PS2_DAT = b;
    repeat (HALF - HALF / 2) @(negedge clk);
    PS2_CLK = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b1;
  endtask

  // bad: 0 good, 1 parity flipped, 2 stop bit 0
  task automatic send_frame(input logic [7:0] b, input int bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ (bad == 1));
    ps2_bit(bad == 2 ? 1'b0 : 1'b1);
    repeat (HALF) @(negedge clk);
    PS2_DAT = 1'b1;
  endtask

  task automatic frame_and_check(input logic [7:0] b, input int bad, input string tag);
    int mv0, kr0, fe0, emv, ekr;
    mv0 = mv_cnt; kr0 = kr_cnt; fe0 = fe_cnt;
    send_frame(b, bad);
    if (bad == 0) model_byte(b, emv, ekr);
    else begin emv = 0; ekr = 0; end
    check({tag, "_mv"}, mv_cnt - mv0, emv);
    check({tag, "_kr"}, kr_cnt - kr0, ekr);
    check({tag, "_fe"}, fe_cnt - fe0, (bad != 0) ? 1 : 0);
    check({tag, "_code"}, make_code, m_code);
    check({tag, "_ext"}, make_extended, m_ext);
  endtask

  initial begin
    int fe0, d, r, bad;
    logic [7:0] b;
    logic [7:0] junk[7];
    junk = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};

    resetn = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_code", make_code, 8'h00);
    check("rst_outs", {make_valid, make_extended, key_released, frame_error}, 4'b0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 1. simple make, with latency from the stop-bit clock edge
    frame_and_check(8'h16, 0, "t1");
    check("t1_latency", mv_cyc - last_fall, SYNC + 1);

    // 2. break sequence
    frame_and_check(8'hF0, 0, "t2a");
    frame_and_check(8'h16, 0, "t2b");

    // 3. extended make then extended break
    frame_and_check(8'hE0, 0, "t3a");
    frame_and_check(8'h75, 0, "t3b");
    frame_and_check(8'hE0, 0, "t3c");
    frame_and_check(8'hF0, 0, "t3d");
    frame_and_check(8'h75, 0, "t3e");

    // 4. parity error then good frame; also a stop-bit error
    frame_and_check(8'h72, 1, "t4a");
    frame_and_check(8'h72, 0, "t4b");
    frame_and_check(8'h3C, 2, "t4c");

    // 5. partial frame abandoned by timeout
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (TO + 200) @(negedge clk);
    check("t5_fe", fe_cnt - fe0, 1);
    d = fe_cyc - last_fall;
    check("t5_when", (d >= TO && d <= TO + SYNC + 3) ? 1 : 0, 1);
    frame_and_check(8'h26, 0, "t5b");

    // start bit read as 1 is ignored silently
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    repeat (30) @(negedge clk);
    check("sb1_fe", fe_cnt - fe0, 0);
    frame_and_check(8'h1C, 0, "sb1");

    // 6. reset mid-frame (clock held high while reset is applied)
    fe0 = fe_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("t6_code", make_code, 8'h00);
    check("t6_outs", {make_valid, make_extended, key_released, frame_error}, 4'b0);
    pq.delete(); m_code = 8'h00; m_ext = 1'b0;
    repeat (TO + 50) @(negedge clk);
    check("t6_fe", fe_cnt - fe0, 0);
    frame_and_check(8'h69, 0, "t6b");

    // random byte stream
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      bad = 0;
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = junk[$urandom_range(0, 6)];
        3: begin b = 8'($urandom_range(0, 255)); bad = $urandom_range(1, 2); end
        default: b = 8'($urandom_range(0, 255));
      endcase
      frame_and_check(b, bad, $sformatf("rnd%0d", n));
    end

    check("no_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
